// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one fetch at a time to
// instruction memory, squashes fetches invalidated by jumps, holds results for decode.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        squash, squash_n;
  logic [31:0] inst_q, inst_n;
  logic [31:0] inst_addr_q, inst_addr_n;
  logic [31:0] jump_pc;

  assign jump_pc = jump_addr_i & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      pc          <= PC_INIT;
      squash      <= 1'b0;
      inst_q      <= '0;
      inst_addr_q <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      squash      <= squash_n;
      inst_q      <= inst_n;
      inst_addr_q <= inst_addr_n;
    end
  end

  // A jump always wins over same-cycle grant, response or decode accept.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    squash_n    = squash;
    inst_n      = inst_q;
    inst_addr_n = inst_addr_q;
    case (state)
      S_IDLE: begin
        state_n = S_REQ;
        if (jump_en_i) pc_n = jump_pc;
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          inst_addr_n = pc;
          state_n     = S_WAIT;
          if (jump_en_i) begin
            pc_n     = jump_pc;
            squash_n = 1'b1;
          end else begin
            pc_n = pc + 32'd4;
          end
        end else if (jump_en_i) begin
          pc_n = jump_pc;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          squash_n = 1'b0;
          if (jump_en_i) begin
            pc_n    = jump_pc;
            state_n = S_REQ;
          end else if (squash) begin
            state_n = S_REQ;
          end else begin
            inst_n  = mem_rdata_i;
            state_n = S_OUT;
          end
        end else if (jump_en_i) begin
          pc_n     = jump_pc;
          squash_n = 1'b1;
        end
      end
      S_OUT: begin
        if (jump_en_i) begin
          pc_n    = jump_pc;
          state_n = S_REQ;
        end else if (inst_ready_i) begin
          state_n = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign mem_req_o    = (state == S_REQ);
  assign mem_addr_o   = pc;
  assign inst_valid_o = (state == S_OUT);
  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        ready = 1'b1;
  logic        req, valid;
  logic [31:0] addr, inst, iaddr;

  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        one = 1'b1;
  logic        zero = 1'b0;
  logic [31:0] zero32 = '0;
  logic        req2, valid2;
  logic [31:0] addr2, inst2, iaddr2;

  if_fetch_ctrl dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .mem_req_o(req), .mem_addr_o(addr), .mem_gnt_i(gnt),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .inst_valid_o(valid), .inst_o(inst), .inst_addr_o(iaddr), .inst_ready_i(ready)
  );

  if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .jump_en_i(zero), .jump_addr_i(zero32),
    .mem_req_o(req2), .mem_addr_o(addr2), .mem_gnt_i(one),
    .mem_rvalid_i(rvalid2), .mem_rdata_i(rdata2),
    .inst_valid_o(valid2), .inst_o(inst2), .inst_addr_o(iaddr2), .inst_ready_i(one)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Model: one fetch may be outstanding; a result may be held for decode.
  logic        m_init = 1'b0;
  logic        m_started, m_out, m_drop, m_hold;
  logic [31:0] m_pc, m_inst, m_iaddr;

  always @(posedge clk) begin
    logic [31:0] tgt;
    tgt = jump_addr & 32'hFFFF_FFFC;
    if (!rst) begin
      m_init = 1'b1; m_started = 1'b0; m_pc = 32'h0; m_out = 1'b0;
      m_drop = 1'b0; m_hold = 1'b0; m_inst = '0; m_iaddr = '0;
    end else if (m_init) begin
      if (!m_started) begin
        m_started = 1'b1;
        if (jump_en) m_pc = tgt;
      end else if (!m_out && !m_hold) begin
        if (gnt) begin
          m_out = 1'b1;
          m_iaddr = m_pc;
          m_pc = m_pc + 32'd4;
          if (jump_en) begin m_pc = tgt; m_drop = 1'b1; end
        end else if (jump_en) m_pc = tgt;
      end else if (m_out) begin
        if (rvalid) begin
          m_out = 1'b0;
          if (jump_en) begin m_pc = tgt; m_drop = 1'b0; end
          else if (m_drop) m_drop = 1'b0;
          else begin m_hold = 1'b1; m_inst = rdata; end
        end else if (jump_en) begin m_pc = tgt; m_drop = 1'b1; end
      end else begin
        if (jump_en) begin m_hold = 1'b0; m_pc = tgt; end
        else if (ready) m_hold = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic m_req;
      m_req = m_started && !m_out && !m_hold;
      check("model_req", {31'b0, req}, {31'b0, m_req});
      if (m_req) check("model_addr", addr, m_pc);
      check("model_valid", {31'b0, valid}, {31'b0, m_hold});
      if (m_hold) begin
        check("model_inst", inst, m_inst);
        check("model_iaddr", iaddr, m_iaddr);
      end
    end
  end

  // Stimulus: one clock step with an auto memory responder (rvalid one cycle after grant).
  int unsigned cyc = 0;
  bit auto_rsp = 1'b1;
  logic [31:0] gq_addr[$];
  int unsigned gq_cyc[$];
  logic [31:0] dq_addr[$];
  logic [31:0] dq_data[$];
  logic [31:0] g2q[$];

  task automatic tick();
    logic g, g2;
    logic [31:0] a, a2;
    g  = (req === 1'b1) && gnt;
    a  = addr;
    g2 = (req2 === 1'b1);
    a2 = addr2;
    if (g) begin gq_addr.push_back(a); gq_cyc.push_back(cyc); end
    if (g2) g2q.push_back(a2);
    if (valid === 1'b1 && ready && !jump_en) begin
      dq_addr.push_back(iaddr);
      dq_data.push_back(inst);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (auto_rsp) begin
      rvalid = g;
      rdata  = g ? data_of(a) : '0;
    end
    rvalid2 = g2;
    rdata2  = g2 ? data_of(a2) : '0;
  endtask

  task automatic do_reset();
    rst = 1'b0; auto_rsp = 1'b1; jump_en = 1'b0; gnt = 1'b1; ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    gq_addr.delete(); gq_cyc.delete(); dq_addr.delete(); dq_data.delete(); g2q.delete();
  endtask

  initial begin
    bit saw;
    int unsigned hits;

    // reset state
    do_reset();
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_addr2", addr2, 32'hFFFF_FFFC);

    // zero-wait streaming
    for (int i = 0; i < 40 && gq_addr.size() < 3; i++) tick();
    check("t1_ngrant", gq_addr.size(), 32'd3);
    if (gq_addr.size() >= 3) begin
      check("t1_g0", gq_addr[0], 32'h0);
      check("t1_g1", gq_addr[1], 32'h4);
      check("t1_g2", gq_addr[2], 32'h8);
      check("t1_gap01", gq_cyc[1] - gq_cyc[0], 32'd3);
      check("t1_gap12", gq_cyc[2] - gq_cyc[1], 32'd3);
    end
    check("t1_ndeliv", dq_addr.size(), 32'd2);
    if (dq_addr.size() >= 2) begin
      check("t1_d0_addr", dq_addr[0], 32'h0);
      check("t1_d0_data", dq_data[0], 32'hDEAD_BEEF);
      check("t1_d1_addr", dq_addr[1], 32'h4);
      check("t1_d1_data", dq_data[1], 32'hDEAD_BEEB);
    end

    // decode stall
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 20 && valid !== 1'b1; i++) tick();
    check("t2_valid", {31'b0, valid}, 32'd1);
    check("t2_inst", inst, 32'hDEAD_BEEF);
    check("t2_iaddr", iaddr, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_valid", {31'b0, valid}, 32'd1);
      check("t2_hold_inst", inst, 32'hDEAD_BEEF);
      check("t2_hold_iaddr", iaddr, 32'h0);
      check("t2_hold_noreq", {31'b0, req}, 32'd0);
    end
    ready = 1'b1;
    tick();
    for (int i = 0; i < 10 && req !== 1'b1; i++) tick();
    check("t2_next_req", {31'b0, req}, 32'd1);
    check("t2_next_addr", addr, 32'h4);

    // jump coincident with grant at pc=8
    do_reset();
    for (int i = 0; i < 40 && !(req === 1'b1 && addr == 32'h8); i++) tick();
    check("t3_at8", {31'b0, req === 1'b1 && addr == 32'h8}, 32'd1);
    jump_en = 1'b1; jump_addr = 32'h0000_0103;
    tick();
    jump_en = 1'b0; jump_addr = '0;
    saw = 1'b0;
    for (int i = 0; i < 10 && req !== 1'b1; i++) begin
      if (valid === 1'b1) saw = 1'b1;
      tick();
    end
    check("t3_no_valid", {31'b0, saw}, 32'd0);
    check("t3_req", {31'b0, req}, 32'd1);
    check("t3_target", addr, 32'h0000_0100);
    for (int i = 0; i < 10 && valid !== 1'b1; i++) tick();
    check("t3_iaddr", iaddr, 32'h0000_0100);
    check("t3_inst", inst, 32'hDEAD_BFEF);
    hits = 0;
    foreach (dq_addr[k]) if (dq_addr[k] == 32'h8) hits++;
    check("t3_no8", hits, 32'd0);

    // jump while holding inst@4 with ready high
    do_reset();
    for (int i = 0; i < 40 && !(valid === 1'b1 && iaddr == 32'h4); i++) tick();
    check("t4_hold4", {31'b0, valid === 1'b1 && iaddr == 32'h4}, 32'd1);
    jump_en = 1'b1; jump_addr = 32'h0000_0200;
    tick();
    jump_en = 1'b0; jump_addr = '0;
    check("t4_valid_drop", {31'b0, valid}, 32'd0);
    check("t4_req", {31'b0, req}, 32'd1);
    check("t4_target", addr, 32'h0000_0200);

    // RESET_PC at top of address space wraps
    do_reset();
    for (int i = 0; i < 30 && g2q.size() < 2; i++) tick();
    check("t5_ngrant", g2q.size(), 32'd2);
    if (g2q.size() >= 2) begin
      check("t5_g0", g2q[0], 32'hFFFF_FFFC);
      check("t5_g1", g2q[1], 32'h0);
    end

    // reset while waiting, stale response after release
    do_reset();
    auto_rsp = 1'b0; rvalid = 1'b0;
    for (int i = 0; i < 20 && gq_addr.size() < 1; i++) tick();
    check("t6_granted", gq_addr.size(), 32'd1);
    rst = 1'b0; gnt = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rvalid = 1'b1; rdata = 32'h0BAD_0BAD;
    tick();
    rvalid = 1'b0; rdata = '0;
    check("t6_stale_ignored", {31'b0, valid}, 32'd0);
    check("t6_req", {31'b0, req}, 32'd1);
    check("t6_addr", addr, 32'h0);
    gnt = 1'b1; auto_rsp = 1'b1;
    for (int i = 0; i < 10 && valid !== 1'b1; i++) tick();
    check("t6_valid", {31'b0, valid}, 32'd1);
    check("t6_iaddr", iaddr, 32'h0);
    check("t6_inst", inst, 32'hDEAD_BEEF);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller that owns the program counter and sequences it against the instruction-memory port. It issues one fetch at a time, advances the PC by 4 per accepted fetch, and redirects on jumps. Fetches that a jump invalidates are squashed. Each returned instruction is held until the decode stage accepts it. The block sits between the core's branch/jump resolution logic and the instruction bus, and feeds the IF/ID boundary.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- jump_en_i  input  1  redirect request from execute; one-cycle pulse
- jump_addr_i  input  32  redirect target; bits [1:0] ignored (treated as 0)
- mem_req_o  output  1  fetch request to instruction memory
- mem_addr_o  output  32  fetch address; valid while mem_req_o=1
- mem_gnt_i  input  1  memory accepted request this cycle (only meaningful while mem_req_o=1)
- mem_rvalid_i  input  1  read data valid; one cycle per granted request, ≥1 cycle after grant
- mem_rdata_i  input  32  instruction word
- inst_valid_o  output  1  instruction available to decode
- inst_o  output  32  fetched instruction
- inst_addr_o  output  32  address of inst_o
- inst_ready_i  input  1  decode consumes inst_o this cycle when inst_valid_o=1

## Operation

- Registers: pc (next fetch address), state, squash flag, inst_o, inst_addr_o.
- pc[1:0] is always 0. pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0) with no error.
- States:
  - S_IDLE: reset state. mem_req_o=0. Goes unconditionally to S_REQ next cycle.
  - S_REQ: mem_req_o=1, mem_addr_o=pc.
    - mem_gnt_i=1: inst_addr_o<=pc, pc<=pc+4, go to S_WAIT.
    - No grant: stay; address held stable unless a jump occurs.
  - S_WAIT: mem_req_o=0.
    - mem_rvalid_i=1 with squash=0: inst_o<=mem_rdata_i, inst_valid_o<=1, go to S_OUT.
    - mem_rvalid_i=1 with squash=1: drop data, clear squash, go to S_REQ.
  - S_OUT: inst_valid_o=1, mem_req_o=0.
    - inst_ready_i=1: inst_valid_o<=0, go to S_REQ.
- Jump handling (jump_en_i=1); jump has priority over same-cycle events:
  - S_IDLE: pc<=jump_addr_i.
  - S_REQ, no grant: pc<=jump_addr_i. mem_addr_o shows the target next cycle; the request stays asserted.
  - S_REQ with mem_gnt_i same cycle: the old-pc fetch is in flight. pc<=jump_addr_i (not pc+4), squash<=1, go to S_WAIT.
  - S_WAIT, no rvalid: pc<=jump_addr_i, squash<=1.
  - S_WAIT with mem_rvalid_i same cycle: drop data, pc<=jump_addr_i, go to S_REQ. Squash stays 0.
  - S_OUT: inst_valid_o<=0 (the instruction is not delivered even if inst_ready_i=1), pc<=jump_addr_i, go to S_REQ.
- mem_rvalid_i outside S_WAIT is ignored; this covers stale responses after reset.
- At most one outstanding request at any time.

## Timing

- Reset (rst=0 at an edge):
  - state=S_IDLE, pc=RESET_PC, squash=0.
  - inst_valid_o=0, inst_o=0, inst_addr_o=0, mem_req_o=0, mem_addr_o=RESET_PC.
  - Reset mid-fetch abandons the fetch with no further handshake.
- First request: mem_req_o=1 one cycle after rst returns high.
- Fetch latency: grant in cycle t and rvalid in t+1 give inst_valid_o=1 in t+2. Zero-wait throughput is one instruction per 3 cycles, plus decode stall.
- Jump in cycle t: mem_addr_o=jump target with mem_req_o=1 no later than t+1, except when squashing an in-flight fetch. In that case the request follows the cycle after the squashed rvalid.
- inst_o and inst_addr_o are stable while inst_valid_o=1 and inst_ready_i=0.
- Outputs are registers or decoded from state only. There is no combinational path from any input to any output.

## Test plan

- Reset release, memory grants immediately with rvalid next cycle, inst_ready_i=1:
  - mem_addr_o sequence 0, 4, 8, with 3-cycle spacing.
  - inst_addr_o matches each address; inst_o equals the returned data.
- Decode stall (inst_ready_i=0 for 5 cycles):
  - inst_valid_o, inst_o and inst_addr_o hold.
  - mem_req_o stays 0.
  - Next request goes to the following address only after ready.
- Jump to 32'h0000_0103 in the same cycle as a grant at pc=8:
  - Response for 8 is dropped; inst_valid_o stays 0.
  - Next request address is 32'h0000_0100.
- Jump during S_OUT holding inst@4, with inst_ready_i=1 in the same cycle:
  - inst@4 is not counted as consumed; valid drops.
  - Next mem_addr_o is the jump target.
- RESET_PC=32'hFFFF_FFFC: the fetch after a grant is at address 0 (wrap).
- rst=0 while in S_WAIT, then a stale rvalid arrives 2 cycles after release:
  - The stale response is ignored.
  - Fetches restart at RESET_PC; inst_valid_o stays 0 until the RESET_PC data returns.
